dcache_controller: RTL and testbench

Direct-mapped, write-back, write-allocate L1 data cache sitting between the core's load/store port (ALU address, rs2 store data, funct3 mask, rd_en/wr_en) and the shared memory bus. Hits complete in the same cycle so the single-cycle core keeps running. Misses assert `cpu_stall`, optionally write back the dirty victim line, and refill the line beat by beat over a req/ack bus. The load result feeds the write-back mux exactly as the flat data memory did.

---
 rtl/dcache_pkg.sv | 33 +++
 rtl/dcache_lane_align.sv | 47 ++++
 rtl/dcache_controller.sv | 190 +++++++++++++++++++
 tb/tb_dcache_controller.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types, funct3 codes and geometry helpers for the data cache
package dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_REFILL,
    ST_RESPOND
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int unsigned DEF_SETS  = 16;
  localparam int unsigned DEF_WORDS = 4;

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned word_w(input int unsigned words);
    return $clog2(words);
  endfunction

  // Byte offset is always two bits; the tag takes whatever is left of 32.
  function automatic int unsigned tag_w(input int unsigned sets, input int unsigned words);
    return 32 - $clog2(sets) - $clog2(words) - 2;
  endfunction

endpackage

// File: rtl/dcache_lane_align.sv
// rtl/dcache_lane_align.sv - load lane extract/extend and store byte-enable/replication
module dcache_lane_align
  import dcache_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  mask_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [3:0]  be_o,
  output logic [31:0] store_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Misaligned halves use addr[1] only and words ignore addr[1:0], so alignment is implicit.
  always_comb begin
    byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    load_o   = word_i;
    be_o     = 4'b1111;
    store_o  = wdata_i;
    case (mask_i)
      F3_LB:   load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  load_o = {24'h0, byte_sel};
      F3_LH:   load_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  load_o = {16'h0, half_sel};
      default: load_o = word_i;
    endcase
    case (mask_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        store_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        store_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        store_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate L1 data cache
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned SETS  = DEF_SETS,
  parameter int unsigned WORDS = DEF_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rd_en,
  input  logic        cpu_wr_en,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_mask,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned IW     = idx_w(SETS);
  localparam int unsigned WW     = word_w(WORDS);
  localparam int unsigned TW     = tag_w(SETS, WORDS);
  localparam int unsigned IDX_LO = WW + 2;
  localparam int unsigned TAG_LO = IW + WW + 2;

  logic [IW-1:0] idx;
  logic [WW-1:0] wsel;
  logic [TW-1:0] tag;

  logic [SETS-1:0] valid_q, dirty_q;
  logic [TW-1:0]   tag_q  [SETS];
  logic [31:0]     data_q [SETS][WORDS];

  state_e        state_q, state_d;
  logic [WW-1:0] beat_q, beat_d, beat_nxt;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;

  logic        hit, cpu_req, serve, ack_ok, last_beat, refill_done, store_en;
  logic [31:0] line_word, load_data, store_rep, store_word;
  logic [3:0]  be;

  assign idx  = cpu_addr[TAG_LO-1:IDX_LO];
  assign wsel = cpu_addr[IDX_LO-1:2];
  assign tag  = cpu_addr[31:TAG_LO];

  assign hit         = valid_q[idx] && (tag_q[idx] == tag);
  assign cpu_req     = cpu_rd_en || cpu_wr_en;
  assign serve       = hit && (state_q == ST_IDLE || state_q == ST_RESPOND);
  assign ack_ok      = mem_req_q && mem_ack;
  assign last_beat   = (beat_q == WW'(WORDS - 1));
  assign beat_nxt    = beat_q + 1'b1;
  assign refill_done = (state_q == ST_REFILL) && ack_ok && last_beat;
  assign store_en    = cpu_wr_en && serve;
  assign line_word   = data_q[idx][wsel];

  assign cpu_stall = (state_q == ST_IDLE && cpu_req && !hit) ||
                     state_q == ST_WRITEBACK || state_q == ST_REFILL;
  assign cpu_rdata = (cpu_rd_en && serve) ? load_data : 32'h0;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  dcache_lane_align u_align (
    .addr_lo_i (cpu_addr[1:0]),
    .mask_i    (cpu_mask),
    .word_i    (line_word),
    .wdata_i   (cpu_wdata),
    .load_o    (load_data),
    .be_o      (be),
    .store_o   (store_rep)
  );

  always_comb begin
    store_word = line_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) store_word[8*b +: 8] = store_rep[8*b +: 8];
    end
  end

  function automatic logic [31:0] beat_addr(input logic [TW-1:0] t, input logic [IW-1:0] i,
                                            input logic [WW-1:0] b);
    return {t, i, b, 2'b00};
  endfunction

  // Bus outputs are registered: each beat is launched one cycle ahead from here.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req && !hit) begin
          beat_d    = '0;
          mem_req_d = 1'b1;
          if (valid_q[idx] && dirty_q[idx]) begin
            state_d     = ST_WRITEBACK;
            mem_we_d    = 1'b1;
            mem_addr_d  = beat_addr(tag_q[idx], idx, '0);
            mem_wdata_d = data_q[idx][0];
          end else begin
            state_d     = ST_REFILL;
            mem_we_d    = 1'b0;
            mem_addr_d  = beat_addr(tag, idx, '0);
            mem_wdata_d = 32'h0;
          end
        end
      end
      ST_WRITEBACK: begin
        if (ack_ok) begin
          if (last_beat) begin
            state_d   = ST_REFILL;
            beat_d    = '0;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
          end else begin
            beat_d      = beat_nxt;
            mem_addr_d  = beat_addr(tag_q[idx], idx, beat_nxt);
            mem_wdata_d = data_q[idx][beat_nxt];
          end
        end
      end
      ST_REFILL: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = beat_addr(tag, idx, beat_q);
          mem_wdata_d = 32'h0;
        end else if (ack_ok) begin
          if (last_beat) begin
            state_d   = ST_RESPOND;
            beat_d    = '0;
            mem_req_d = 1'b0;
          end else begin
            beat_d     = beat_nxt;
            mem_addr_d = beat_addr(tag, idx, beat_nxt);
          end
        end
      end
      ST_RESPOND: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (refill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
      if (store_en) dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid gates them.
  always_ff @(posedge clk) begin
    if (state_q == ST_REFILL && ack_ok) data_q[idx][beat_q] <= mem_rdata;
    if (refill_done) tag_q[idx] <= tag;
    if (store_en) data_q[idx][wsel] <= store_word;
  end

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - directed bench with a flat-memory reference and bus responder
module tb_dcache_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_rd_en, cpu_wr_en;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [2:0]  cpu_mask;
  logic        cpu_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;

  always #5 clk = ~clk;

  dcache_controller #(.SETS(16), .WORDS(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_mask(cpu_mask), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference: the cache must look like a flat byte memory (CPU stores over backing memory).
  logic [31:0] bmem  [logic [31:0]];
  logic [7:0]  cpu_b [logic [31:0]];
  bit          m_valid [16];
  bit          m_dirty [16];
  logic [23:0] m_tag   [16];

  function automatic logic [31:0] back_w(input logic [31:0] wa);
    return bmem.exists(wa) ? bmem[wa] : (wa ^ 32'hC0DE0000);
  endfunction

  function automatic logic [7:0] vis_b(input logic [31:0] a);
    logic [31:0] w;
    if (cpu_b.exists(a)) return cpu_b[a];
    w = back_w({a[31:2], 2'b00});
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] vis_w(input logic [31:0] wa);
    return {vis_b(wa + 32'd3), vis_b(wa + 32'd2), vis_b(wa + 32'd1), vis_b(wa)};
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] m);
    logic [7:0]  b;
    logic [15:0] h;
    b = vis_b(a);
    h = {vis_b({a[31:1], 1'b1}), vis_b({a[31:1], 1'b0})};
    case (m)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return vis_w({a[31:2], 2'b00});
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    cpu_b.delete();
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       seen[$];
  int          wait_cyc = 0;
  int          wcnt = 0;
  int          pbeats = 0;
  int          acks = 0;
  bit          have_prev = 1'b0;
  bit          must_drop = 1'b0;
  bit          junk_ack = 1'b0;
  logic        prev_we;
  logic [31:0] prev_addr, prev_wdata;

  // Bus slave: acks after wait_cyc idle cycles per beat, checks stability and the post-phase drop.
  always @(negedge clk) begin
    beat_t e;
    mem_ack   = 1'b0;
    mem_rdata = 32'hBAD0BAD0;
    if (reset) begin
      wcnt = 0; pbeats = 0; have_prev = 1'b0; must_drop = 1'b0;
    end else begin
      if (must_drop) begin
        chk("req_drop_after_phase", {31'h0, mem_req}, 32'h0);
        must_drop = 1'b0;
      end
      if (mem_req) begin
        if (have_prev) begin
          chk("hold_addr", mem_addr, prev_addr);
          chk("hold_we", {31'h0, mem_we}, {31'h0, prev_we});
          chk("hold_wdata", mem_wdata, prev_wdata);
        end
        if (wcnt == wait_cyc) begin
          mem_ack = 1'b1;
          wcnt = 0;
          have_prev = 1'b0;
          e.we = mem_we; e.addr = mem_addr; e.data = mem_wdata;
          seen.push_back(e);
          if (mem_we) bmem[mem_addr] = mem_wdata;
          else mem_rdata = back_w(mem_addr);
          acks++;
          pbeats++;
          if (pbeats == 4) begin
            pbeats = 0;
            must_drop = 1'b1;
          end
        end else begin
          wcnt++;
          have_prev = 1'b1;
          prev_addr = mem_addr; prev_we = mem_we; prev_wdata = mem_wdata;
        end
      end else begin
        wcnt = 0;
        have_prev = 1'b0;
        if (junk_ack) mem_ack = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (!reset && cpu_rd_en && !cpu_stall)
      chk("load_data", cpu_rdata, model_load(cpu_addr, cpu_mask));
    if (!reset && !cpu_rd_en && !cpu_wr_en)
      chk("idle_no_stall", {31'h0, cpu_stall}, 32'h0);
  end

  // One CPU access from a negedge: measures stall cycles, checks bus beats, updates the model.
  task automatic access(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] m, input int w, output int stalls, output logic [31:0] rd);
    int          idx, exp_st;
    bit          miss, vdirty;
    logic [31:0] old_base, new_base;
    beat_t       exp_q[$];
    beat_t       e;
    idx      = int'(a[7:4]);
    miss     = !(m_valid[idx] && m_tag[idx] == a[31:8]);
    vdirty   = miss && m_valid[idx] && m_dirty[idx];
    old_base = {m_tag[idx], a[7:4], 4'h0};
    new_base = {a[31:4], 4'h0};
    for (int k = 0; k < 4; k++) begin
      if (vdirty) begin
        e.we = 1'b1; e.addr = old_base + 32'(4 * k); e.data = vis_w(e.addr);
        exp_q.push_back(e);
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (miss) begin
        e.we = 1'b0; e.addr = new_base + 32'(4 * k); e.data = 32'h0;
        exp_q.push_back(e);
      end
    end
    exp_st = !miss ? 0 : (vdirty ? 2 + 8 * (w + 1) : 1 + 4 * (w + 1));
    seen.delete();
    wait_cyc  = w;
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_mask  = m;
    cpu_rd_en = !wr;
    cpu_wr_en = wr;
    #1;
    stalls = 0;
    while (cpu_stall && stalls < 500) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (stalls >= 500) begin
      nvec++; nerr++;
      $display("FAIL stall_timeout: addr %08h still stalled after %0d cycles", a, stalls);
    end
    rd = cpu_rdata;
    @(negedge clk);
    cpu_rd_en = 1'b0;
    cpu_wr_en = 1'b0;
    chk("stall_cycles", 32'(stalls), 32'(exp_st));
    chk("beat_count", 32'(seen.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < seen.size(); i++) begin
      chk("beat_we", {31'h0, seen[i].we}, {31'h0, exp_q[i].we});
      chk("beat_addr", seen[i].addr, exp_q[i].addr);
      if (exp_q[i].we) chk("beat_wdata", seen[i].data, exp_q[i].data);
    end
    if (miss) begin
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = a[31:8];
    end
    if (wr) begin
      m_dirty[idx] = 1'b1;
      case (m[1:0])
        2'b00: cpu_b[a] = wd[7:0];
        2'b01: begin
          cpu_b[{a[31:1], 1'b0}] = wd[7:0];
          cpu_b[{a[31:1], 1'b1}] = wd[15:8];
        end
        default: for (int k = 0; k < 4; k++) cpu_b[{a[31:2], 2'(k)}] = wd[8*k +: 8];
      endcase
    end
  endtask

  int          st, st0, guard, a0;
  logic [31:0] rd;

  initial begin
    reset = 1'b1;
    cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_mask = 3'b010;
    model_reset();
    #3;
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_cpu_stall", {31'h0, cpu_stall}, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    access(1'b0, 32'h100, 32'h0, 3'b010, 0, st, rd);
    chk("cold_stall_lit", 32'(st), 32'd5);
    chk("cold_rdata_lit", rd, 32'hC0DE0100);
    chk("cold_beat0_lit", seen[0].addr, 32'h100);
    chk("cold_beat3_lit", seen[3].addr, 32'h10C);
    access(1'b0, 32'h104, 32'h0, 3'b010, 0, st, rd);
    chk("hit_rdata_lit", rd, 32'hC0DE0104);

    access(1'b1, 32'h101, 32'h80, 3'b000, 0, st, rd);
    access(1'b0, 32'h101, 32'h0, 3'b000, 0, st, rd);
    chk("lb_lit", rd, 32'hFFFFFF80);
    access(1'b0, 32'h101, 32'h0, 3'b100, 0, st, rd);
    chk("lbu_lit", rd, 32'h00000080);

    access(1'b0, 32'h200, 32'h0, 3'b010, 0, st, rd);
    chk("dirty_stall_lit", 32'(st), 32'd10);
    chk("wb0_wdata_lit", seen[0].data, 32'hC0DE8000);
    chk("refill_after_wb_lit", seen[4].addr, 32'h200);
    chk("dirty_rdata_lit", rd, 32'hC0DE0200);

    access(1'b0, 32'h310, 32'h0, 3'b010, 3, st0, rd);
    chk("wait3_stall_lit", 32'(st0), 32'd17);
    access(1'b0, 32'h410, 32'h0, 3'b010, 0, st, rd);
    chk("wait_growth", 32'(st0 - st), 32'd12);
    access(1'b1, 32'h410, 32'h12345678, 3'b010, 0, st, rd);
    junk_ack = 1'b1;
    access(1'b0, 32'h510, 32'h0, 3'b010, 3, st, rd);
    junk_ack = 1'b0;
    chk("dirty_wait3_stall_lit", 32'(st), 32'd34);
    chk("wb_sw_wdata_lit", seen[0].data, 32'h12345678);

    access(1'b1, 32'h302, 32'hBEEF, 3'b001, 0, st, rd);
    chk("sh_miss_stall_lit", 32'(st), 32'd5);
    access(1'b0, 32'h302, 32'h0, 3'b101, 0, st, rd);
    chk("lhu_lit", rd, 32'h0000BEEF);
    access(1'b0, 32'h302, 32'h0, 3'b001, 0, st, rd);
    chk("lh_lit", rd, 32'hFFFFBEEF);
    access(1'b0, 32'h303, 32'h0, 3'b010, 0, st, rd);
    chk("lw_misaligned_lit", rd, 32'hBEEF0300);
    access(1'b0, 32'h400, 32'h0, 3'b010, 0, st, rd);
    chk("respond_store_dirty_lit", seen[0].data, 32'hBEEF0300);
    access(1'b1, 32'h400, 32'h11, 3'b000, 0, st, rd);

    wait_cyc = 2;
    seen.delete();
    a0 = acks;
    cpu_addr = 32'h5C0; cpu_mask = 3'b010; cpu_rd_en = 1'b1;
    guard = 0;
    while (acks < a0 + 2 && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("rst_reached_beat2", 32'(acks - a0), 32'd2);
    @(negedge clk);
    #2;
    chk("rst_pre_addr_lit", mem_addr, 32'h5C8);
    chk("rst_pre_req", {31'h0, mem_req}, 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_req", {31'h0, mem_req}, 32'h0);
    chk("rst_async_addr", mem_addr, 32'h0);
    cpu_rd_en = 1'b0;
    model_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    access(1'b0, 32'h5C0, 32'h0, 3'b010, 0, st, rd);
    chk("rst_refill_beat0_lit", seen[0].addr, 32'h5C0);
    chk("rst_refill_rdata_lit", rd, 32'hC0DE05C0);
    access(1'b0, 32'h400, 32'h0, 3'b010, 0, st, rd);
    chk("rst_lost_dirty_lit", rd, 32'hC0DE0400);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
